// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if -- request/response bundle between interrupt sources and
// the VIC front-end arbiter.
//   nvIRQRequest               : non-vectored IRQ request (level)
//   vIRQRequest[15:0]          : vectored IRQ requests, bit i = source i (level)
//   wire_IRQArbiter_HandlerNum : registered index of winning vectored source
//   wire_IRQArbiter_IsnvIRQ    : registered flag, winner is the non-vectored line
//   wire_VICIRQRequest         : registered combined IRQ request to the core
// modport master : request side (drives requests, observes arbiter result)
// modport slave  : arbiter side
interface irq_arbiter_if;
  logic        nvIRQRequest;
  logic [15:0] vIRQRequest;
  logic [3:0]  wire_IRQArbiter_HandlerNum;
  logic        wire_IRQArbiter_IsnvIRQ;
  logic        wire_VICIRQRequest;

  modport master (
    output nvIRQRequest,
    output vIRQRequest,
    input  wire_IRQArbiter_HandlerNum,
    input  wire_IRQArbiter_IsnvIRQ,
    input  wire_VICIRQRequest
  );

  modport slave (
    input  nvIRQRequest,
    input  vIRQRequest,
    output wire_IRQArbiter_HandlerNum,
    output wire_IRQArbiter_IsnvIRQ,
    output wire_VICIRQRequest
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter -- fixed-priority interrupt arbiter in front of the VIC.
// Merges one non-vectored and 16 vectored IRQ lines into one core request,
// selects the winning vectored handler number and flags a non-vectored win.
// All outputs come straight from flip-flops (one cycle latency).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (clears all outputs)
//   bus : irq_arbiter_if.slave -- requests in, arbitration result out
// Parameter:
//   LOW_INDEX_FIRST : 1 = lowest vectored index wins, 0 = highest wins
module irq_arbiter #(
  parameter int unsigned LOW_INDEX_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  irq_arbiter_if.slave bus
);

  logic       w_any;
  logic [3:0] w_win;
  logic [3:0] r_handler_num;
  logic       r_is_nv;
  logic       r_request;

  assign w_any = bus.nvIRQRequest | (|bus.vIRQRequest);

  // Scan so that the preferred index is visited last and therefore overrides.
  always_comb begin
    w_win = '0;
    if (LOW_INDEX_FIRST != 0) begin
      for (int unsigned i = 16; i > 0; i--) begin
        if (bus.vIRQRequest[i-1]) w_win = 4'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (bus.vIRQRequest[i]) w_win = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_handler_num <= '0;
      r_is_nv       <= 1'b0;
      r_request     <= 1'b0;
    end else begin
      r_request     <= w_any;
      r_is_nv       <= bus.nvIRQRequest;
      // Non-vectored line outranks every vectored source.
      r_handler_num <= bus.nvIRQRequest ? 4'h0 : w_win;
    end
  end

  assign bus.wire_IRQArbiter_HandlerNum = r_handler_num;
  assign bus.wire_IRQArbiter_IsnvIRQ    = r_is_nv;
  assign bus.wire_VICIRQRequest         = r_request;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter -- directed bench for irq_arbiter. Two instances (low-index
// and high-index priority) see identical requests; expected results are
// hand-computed per step for both priority orders.
module tb_irq_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Expected values currently held by the DUT outputs (used to confirm
  // outputs do not move before the next edge).
  logic [3:0] p_hl;
  logic [3:0] p_hh;
  logic       p_nv;
  logic       p_req;

  irq_arbiter_if bus_lo ();
  irq_arbiter_if bus_hi ();

  irq_arbiter #(.LOW_INDEX_FIRST(1)) u_lo (.clk(clk), .rst(rst), .bus(bus_lo.slave));
  irq_arbiter #(.LOW_INDEX_FIRST(0)) u_hi (.clk(clk), .rst(rst), .bus(bus_hi.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] hl, input logic [3:0] hh,
                           input logic nv, input logic req);
    chk1({tag, ".lo.HandlerNum"}, bus_lo.wire_IRQArbiter_HandlerNum, hl);
    chk1({tag, ".hi.HandlerNum"}, bus_hi.wire_IRQArbiter_HandlerNum, hh);
    chk1({tag, ".lo.IsnvIRQ"}, {3'b0, bus_lo.wire_IRQArbiter_IsnvIRQ}, {3'b0, nv});
    chk1({tag, ".hi.IsnvIRQ"}, {3'b0, bus_hi.wire_IRQArbiter_IsnvIRQ}, {3'b0, nv});
    chk1({tag, ".lo.VICIRQRequest"}, {3'b0, bus_lo.wire_VICIRQRequest}, {3'b0, req});
    chk1({tag, ".hi.VICIRQRequest"}, {3'b0, bus_hi.wire_VICIRQRequest}, {3'b0, req});
  endtask

  task automatic drive(input logic nv, input logic [15:0] v);
    bus_lo.nvIRQRequest = nv;
    bus_lo.vIRQRequest  = v;
    bus_hi.nvIRQRequest = nv;
    bus_hi.vIRQRequest  = v;
  endtask

  // Apply inputs mid-cycle, confirm outputs hold until the edge, then check
  // the registered result one edge later.
  task automatic step(input string tag, input logic nv, input logic [15:0] v,
                      input logic [3:0] hl, input logic [3:0] hh,
                      input logic exp_nv, input logic req);
    @(negedge clk);
    drive(nv, v);
    #1;
    check_all({tag, ".hold"}, p_hl, p_hh, p_nv, p_req);
    @(posedge clk);
    #1;
    check_all(tag, hl, hh, exp_nv, req);
    p_hl = hl; p_hh = hh; p_nv = exp_nv; p_req = req;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b1, 16'hFFFF);

    // Reset dominates active requests for two edges.
    @(posedge clk); #1;
    check_all("reset1", 4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset2", 4'h0, 4'h0, 1'b0, 1'b0);
    p_hl = 4'h0; p_hh = 4'h0; p_nv = 1'b0; p_req = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset", 4'h0, 4'h0, 1'b1, 1'b1);
    p_hl = 4'h0; p_hh = 4'h0; p_nv = 1'b1; p_req = 1'b1;

    //    tag            nv    v         lo    hi    nv    req
    step("idle",        1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
    step("single8",     1'b0, 16'h0100, 4'h8, 4'h8, 1'b0, 1'b1);
    step("multi0F00",   1'b0, 16'h0F00, 4'h8, 4'hB, 1'b0, 1'b1);
    step("nv_over_v",   1'b1, 16'h0F00, 4'h0, 4'h0, 1'b1, 1'b1);
    step("nv_drop",     1'b0, 16'h0F00, 4'h8, 4'hB, 1'b0, 1'b1);
    step("top15",       1'b0, 16'h8000, 4'hF, 4'hF, 1'b0, 1'b1);
    step("bottom0",     1'b0, 16'h0001, 4'h0, 4'h0, 1'b0, 1'b1);
    step("all",         1'b0, 16'hFFFF, 4'h0, 4'hF, 1'b0, 1'b1);
    step("mixed",       1'b0, 16'h4812, 4'h1, 4'hE, 1'b0, 1'b1);
    step("clear",       1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);

    // Back-to-back toggling: each edge reflects only the preceding inputs.
    step("seq_nv",      1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b1);
    step("seq_0100",    1'b1, 16'h0100, 4'h0, 4'h0, 1'b1, 1'b1);
    step("seq_0F00",    1'b1, 16'h0F00, 4'h0, 4'h0, 1'b1, 1'b1);
    step("seq_nv0",     1'b0, 16'h0F00, 4'h8, 4'hB, 1'b0, 1'b1);
    step("seq_v0",      1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset asserted while a request is active.
    step("pre_midrst",  1'b0, 16'h0100, 4'h8, 4'h8, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all("mid_reset", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("after_midrst", 4'h8, 4'h8, 1'b0, 1'b1);
    p_hl = 4'h8; p_hh = 4'h8; p_nv = 1'b0; p_req = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
